// File: rtl/restoring_divider_cla.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the trial
// subtraction done by a (WIDTH+1)-bit carry-lookahead adder in subtract mode.
module restoring_divider_cla #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a one-cycle request sampled on a rising edge; it is accepted
  // (operands captured) only on an edge where busy=0, i.e. in IDLE or in the DONE cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [WIDTH:0]    p_reg;
  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  d_reg;

  logic              accept;
  logic              last_step;
  logic [WIDTH:0]    t_val;
  logic [WIDTH:0]    b_val;
  logic [WIDTH:0]    s_val;
  logic              cout;
  logic [WIDTH:0]    p_next;
  logic [WIDTH-1:0]  q_next;
  logic              unused_p_msb;

  // Carry-lookahead subtract: every carry is expanded from generate/propagate terms
  // directly, so no carry depends on a neighbouring carry wire.
  function automatic logic [WIDTH+1:0] cla_add(input logic [WIDTH:0] a,
                                               input logic [WIDTH:0] b,
                                               input logic           cin);
    logic [WIDTH:0]   g;
    logic [WIDTH:0]   p;
    logic [WIDTH+1:0] c;
    logic             acc;
    logic             prop;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i <= WIDTH; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & cin);
    end
    return {c[WIDTH+1], p ^ c[WIDTH:0]};
  endfunction

  assign busy         = (state == S_RUN);
  assign done         = (state == S_DONE);
  assign dbg_state    = state;
  // P never exceeds the divisor after a step, so its top bit is never shifted out.
  assign unused_p_msb = p_reg[WIDTH];

  always_comb begin
    accept     = start && (state != S_RUN);
    last_step  = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = (divisor == '0) ? S_DONE : S_RUN;
        else       state_next = S_IDLE;
      end
      S_RUN:   if (last_step) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    t_val         = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    b_val         = ~{1'b0, d_reg};
    {cout, s_val} = cla_add(t_val, b_val, 1'b1);
    p_next        = cout ? s_val : t_val;
    q_next        = {q_reg[WIDTH-2:0], cout};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      p_reg <= '0;
      q_reg <= dividend;
      d_reg <= divisor;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == S_RUN) begin
      cnt   <= cnt + CW'(1);
      p_reg <= p_next;
      q_reg <= q_next;
      if (last_step) begin
        quotient    <= q_next;
        remainder   <= p_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
